eth_frame_buffer: RTL and testbench
===================================

Name: eth_frame_buffer

Overview:
Store-and-forward Ethernet frame buffer between a NoC translator port and a DDR3 Avalon-MM controller. Frames arrive from the NoC as packets of 518-bit beats tagged with a frame ID. Each frame is written to a DDR3 bin selected by the frame ID, then read back and re-injected into the NoC toward the port encoded in the frame ID. A companion stimulus block, pkt_generator, drives the NoC input side in test.

Parameters:
AVL_ADDR_WIDTH, 29, Avalon word address width
AVL_DATA_WIDTH, 518, Avalon data width (512 payload + 6 metadata bits)
AVL_BYTE_EN_WIDTH, AVL_DATA_WIDTH/8, byte-enable width (integer division)
FRAME_ID_WIDTH, 32, frame ID; [31:28] destination port, [27:0] frame number
BIN_ADDR_WIDTH, 8, number of frame bins = 2^8
FRAME_OFFSET_WIDTH, 5, max frame length = 32 beats
NOC_ADDR_WIDTH, 4, NoC destination width
WIDTH_PKT, AVL_DATA_WIDTH+2+FRAME_ID_WIDTH (552), NoC word width

Ports:
clk  in  1  single clock
rst  in  1  asynchronous, active-low reset
noc_data_in  in  WIDTH_PKT  {frame_id[551:520], eop[519], sop[518], data[517:0]}
noc_valid_in  in  4  per-flit valid; a beat is valid when any bit is set
noc_sop_in  in  4  per-flit sideband, ignored (the sop bit in the data word is used)
noc_eop_in  in  4  per-flit sideband, ignored (the eop bit in the data word is used)
noc_ready_out  out  1  input beat accepted when valid && ready
noc_data_out  out  WIDTH_PKT  same format as input
noc_dest_out  out  NOC_ADDR_WIDTH  frame_id[31:28]
noc_valid_out  out  4  4'b1111 on each valid beat, else 0
noc_sop_out, noc_eop_out  out  4  all-ones on the first/last beat
noc_ready_in  in  1  downstream ready
avl_ready  in  1  controller ready
avl_addr  out  AVL_ADDR_WIDTH  word address
avl_wdata  out  AVL_DATA_WIDTH  write data
avl_be  out  AVL_BYTE_EN_WIDTH  all ones
avl_write_req, avl_read_req  out  1  request strobes
avl_size  out  FRAME_OFFSET_WIDTH+1  burst length (reads), 1 for writes
avl_burstbegin  out  1  first cycle of each request
avl_rdata  in  AVL_DATA_WIDTH  read data
avl_rdata_valid  in  1  read data strobe

Behaviour:
- Reset (rst=0, async): all outputs 0 except avl_be = all ones; FSM to IDLE; completion FIFO empty; counters 0.
- Address: {zeros, bin = frame_id[BIN_ADDR_WIDTH-1:0], offset[FRAME_OFFSET_WIDTH-1:0]}.
- Write path: noc_ready_out = avl_ready && (state==IDLE || state==WRITE) && FIFO not full. Each accepted beat becomes a single-beat write in the same cycle (combinational pass-through):
  - avl_write_req=1, avl_size=1, avl_burstbegin=1.
  - A sop beat resets offset to 0; the frame ID is latched on sop.
  - Beats beyond 32 are accepted but not written (avl_write_req=0); the length saturates at 32.
- Frame completion: on the eop beat, push {bin, length (1..32), dest} into a 4-deep completion FIFO.
  - Full FIFO deasserts noc_ready_out.
  - An eop beat on a sop beat gives a one-beat frame.
- FSM states: IDLE, WRITE (between sop and eop), READ_REQ, READ_DATA.
  - IDLE->WRITE on accepted sop without eop.
  - WRITE->IDLE on accepted eop.
  - IDLE->READ_REQ when the FIFO is non-empty, no input beat is valid, and noc_ready_in=1. Writes have priority in IDLE.
  - READ_REQ: assert avl_read_req, avl_burstbegin, addr={bin,0}, size=length until avl_ready; then pop the FIFO and go to READ_DATA.
  - READ_DATA: each avl_rdata_valid produces one registered output beat, one cycle later, with dest, frame ID, sop on beat 0 and eop on beat length-1. Then return to IDLE.
- Downstream must accept during READ_DATA; noc_ready_in is sampled only before issuing the read.
- Mid-frame reset discards the partial frame and all queued frames.

Decomposition:
- Package eth_fb_pkg: field-offset localparams (DATA_LSB, SOP_BIT, EOP_BIT, FID_LSB), state enum, FIFO entry struct {bin, len, dest}.
- One sub-module: eth_fb_cmd_fifo (4-deep synchronous FIFO with full/empty).

Test Plan:
- 4-beat frame, frame_id=32'h3000_0005 -> writes to addr 0xA0..0xA3; then one read with addr 0xA0, size 4; output beats with dest=3, sop on beat 0, eop on beat 3.
- 1-beat frame (sop & eop) -> one write plus a size-1 read; noc_sop_out and noc_eop_out both 4'hF on the same beat.
- 40-beat frame, bin 1 -> 32 writes at 0x20..0x3F, beats 33..40 dropped, read size 32.
- avl_ready low for 3 cycles mid-frame -> noc_ready_out low those 3 cycles, no write lost or duplicated.
- 5 back-to-back frames with noc_ready_in=0 -> after 4 frames noc_ready_out=0; raise noc_ready_in -> frames read out in FIFO order.
- Reset asserted during beat 2 of a frame -> outputs zero, FIFO empty, no read issued.

Source files
------------

// File: rtl/eth_fb_pkg.sv
// Shared widths, NoC word field offsets, FSM states and completion-queue entry.
package eth_fb_pkg;

    localparam int unsigned AVL_ADDR_WIDTH     = 29;
    localparam int unsigned AVL_DATA_WIDTH     = 518;
    localparam int unsigned AVL_BYTE_EN_WIDTH  = AVL_DATA_WIDTH / 8;
    localparam int unsigned FRAME_ID_WIDTH     = 32;
    localparam int unsigned BIN_ADDR_WIDTH     = 8;
    localparam int unsigned FRAME_OFFSET_WIDTH = 5;
    localparam int unsigned NOC_ADDR_WIDTH     = 4;
    localparam int unsigned WIDTH_PKT          = AVL_DATA_WIDTH + 2 + FRAME_ID_WIDTH;
    localparam int unsigned FLIT_WIDTH         = 4;

    localparam int unsigned LEN_WIDTH          = FRAME_OFFSET_WIDTH + 1;
    localparam int unsigned MAX_BEATS          = 1 << FRAME_OFFSET_WIDTH;
    localparam int unsigned FID_MID_WIDTH      = FRAME_ID_WIDTH - NOC_ADDR_WIDTH - BIN_ADDR_WIDTH;
    localparam int unsigned FIFO_DEPTH         = 4;

    // NoC word layout: {frame_id, eop, sop, data}
    localparam int unsigned DATA_LSB = 0;
    localparam int unsigned SOP_BIT  = DATA_LSB + AVL_DATA_WIDTH;
    localparam int unsigned EOP_BIT  = SOP_BIT + 1;
    localparam int unsigned FID_LSB  = EOP_BIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_REQ,
        ST_READ_DATA
    } fb_state_e;

    typedef struct packed {
        logic [BIN_ADDR_WIDTH-1:0] bin;
        logic [LEN_WIDTH-1:0]      len;
        logic [NOC_ADDR_WIDTH-1:0] dest;
    } cmd_entry_t;

    // DDR word address of a beat: {zeros, bin, offset}
    function automatic logic [AVL_ADDR_WIDTH-1:0] make_addr(
        input logic [BIN_ADDR_WIDTH-1:0]     bin,
        input logic [FRAME_OFFSET_WIDTH-1:0] off
    );
        return AVL_ADDR_WIDTH'({bin, off});
    endfunction

endpackage

// File: rtl/eth_fb_cmd_fifo.sv
// Four-entry completion queue of finished frames waiting to be read back.
module eth_fb_cmd_fifo
    import eth_fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  cmd_entry_t push_data,
    input  logic       pop,
    output cmd_entry_t head_c,
    output logic       full_c,
    output logic       empty_c
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    cmd_entry_t          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [PTR_W:0]      count_q;
    logic                do_push;
    logic                do_pop;

    assign full_c  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign empty_c = (count_q == '0);
    assign do_push = push && !full_c;
    assign do_pop  = pop && !empty_c;
    assign head_c  = mem[rd_ptr_q];

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (PTR_W+1)'(1);
                2'b01:   count_q <= count_q - (PTR_W+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only meaningful while counted
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/eth_frame_buffer.sv
// Store-and-forward Ethernet frame buffer: NoC frames -> DDR3 bins -> back to NoC.
module eth_frame_buffer
    import eth_fb_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH_PKT-1:0]         noc_data_in,
    input  logic [FLIT_WIDTH-1:0]        noc_valid_in,
    input  logic [FLIT_WIDTH-1:0]        noc_sop_in,
    input  logic [FLIT_WIDTH-1:0]        noc_eop_in,
    output logic                         noc_ready_out,
    output logic [WIDTH_PKT-1:0]         noc_data_out,
    output logic [NOC_ADDR_WIDTH-1:0]    noc_dest_out,
    output logic [FLIT_WIDTH-1:0]        noc_valid_out,
    output logic [FLIT_WIDTH-1:0]        noc_sop_out,
    output logic [FLIT_WIDTH-1:0]        noc_eop_out,
    input  logic                         noc_ready_in,
    input  logic                         avl_ready,
    output logic [AVL_ADDR_WIDTH-1:0]    avl_addr,
    output logic [AVL_DATA_WIDTH-1:0]    avl_wdata,
    output logic [AVL_BYTE_EN_WIDTH-1:0] avl_be,
    output logic                         avl_write_req,
    output logic                         avl_read_req,
    output logic [LEN_WIDTH-1:0]         avl_size,
    output logic                         avl_burstbegin,
    input  logic [AVL_DATA_WIDTH-1:0]    avl_rdata,
    input  logic                         avl_rdata_valid
);

    logic                      active_q;
    fb_state_e                 state_q;
    fb_state_e                 state_d;
    logic [BIN_ADDR_WIDTH-1:0] fid_bin_q;
    logic [NOC_ADDR_WIDTH-1:0] fid_dest_q;
    logic [LEN_WIDTH-1:0]      wr_len_q;
    cmd_entry_t                rd_cmd_q;
    logic [LEN_WIDTH-1:0]      rd_cnt_q;

    logic                      in_valid_c;
    logic                      in_sop_c;
    logic                      in_eop_c;
    logic [BIN_ADDR_WIDTH-1:0] in_bin_c;
    logic [NOC_ADDR_WIDTH-1:0] in_dest_c;
    logic [BIN_ADDR_WIDTH-1:0] cur_bin_c;
    logic [NOC_ADDR_WIDTH-1:0] cur_dest_c;
    logic [LEN_WIDTH-1:0]      beat_off_c;
    logic [LEN_WIDTH-1:0]      len_next_c;
    logic                      accept_c;
    logic                      wr_en_c;
    logic                      rd_last_c;
    logic                      fifo_pop_c;
    logic                      fifo_full_c;
    logic                      fifo_empty_c;
    cmd_entry_t                push_entry_c;
    cmd_entry_t                head_c;
    logic                      unused_sideband;

    // Flit sideband and frame-number bits are not needed for buffering
    assign unused_sideband = ^{noc_sop_in, noc_eop_in,
                               noc_data_in[FID_LSB + BIN_ADDR_WIDTH +: FID_MID_WIDTH]};

    assign in_valid_c = |noc_valid_in;
    assign in_sop_c   = noc_data_in[SOP_BIT];
    assign in_eop_c   = noc_data_in[EOP_BIT];
    assign in_bin_c   = noc_data_in[FID_LSB +: BIN_ADDR_WIDTH];
    assign in_dest_c  = noc_data_in[FID_LSB + FRAME_ID_WIDTH - NOC_ADDR_WIDTH +: NOC_ADDR_WIDTH];

    // Frame ID comes from the sop beat itself, otherwise from the latched copy
    assign cur_bin_c  = in_sop_c ? in_bin_c  : fid_bin_q;
    assign cur_dest_c = in_sop_c ? in_dest_c : fid_dest_q;
    assign beat_off_c = in_sop_c ? '0 : wr_len_q;
    assign len_next_c = in_sop_c ? LEN_WIDTH'(1)
                      : (wr_len_q == LEN_WIDTH'(MAX_BEATS)) ? wr_len_q
                      : wr_len_q + LEN_WIDTH'(1);

    assign noc_ready_out = active_q && avl_ready && !fifo_full_c &&
                           (state_q == ST_IDLE || state_q == ST_WRITE);
    assign accept_c      = in_valid_c && noc_ready_out;
    assign wr_en_c       = accept_c && (beat_off_c < LEN_WIDTH'(MAX_BEATS));
    assign rd_last_c     = (rd_cnt_q + LEN_WIDTH'(1)) == rd_cmd_q.len;
    assign avl_be        = '1;

    assign push_entry_c.bin  = cur_bin_c;
    assign push_entry_c.len  = len_next_c;
    assign push_entry_c.dest = cur_dest_c;

    eth_fb_cmd_fifo u_cmd_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept_c && in_eop_c),
        .push_data (push_entry_c),
        .pop       (fifo_pop_c),
        .head_c    (head_c),
        .full_c    (fifo_full_c),
        .empty_c   (fifo_empty_c)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            active_q <= 1'b1;
        end
    end

    // Next state, queue pop and Avalon command mux (write pass-through or read burst)
    always_comb begin
        state_d        = state_q;
        fifo_pop_c     = 1'b0;
        avl_addr       = '0;
        avl_wdata      = '0;
        avl_write_req  = 1'b0;
        avl_read_req   = 1'b0;
        avl_size       = '0;
        avl_burstbegin = 1'b0;

        if (wr_en_c) begin
            avl_addr       = make_addr(cur_bin_c, beat_off_c[FRAME_OFFSET_WIDTH-1:0]);
            avl_wdata      = noc_data_in[DATA_LSB +: AVL_DATA_WIDTH];
            avl_write_req  = 1'b1;
            avl_size       = LEN_WIDTH'(1);
            avl_burstbegin = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_c && in_sop_c && !in_eop_c) begin
                    state_d = ST_WRITE;
                end else if (!in_valid_c && !fifo_empty_c && noc_ready_in) begin
                    state_d = ST_READ_REQ;
                end
            end
            ST_WRITE: begin
                if (accept_c && in_eop_c) state_d = ST_IDLE;
            end
            ST_READ_REQ: begin
                avl_addr       = make_addr(head_c.bin, '0);
                avl_read_req   = 1'b1;
                avl_size       = head_c.len;
                avl_burstbegin = 1'b1;
                if (avl_ready) begin
                    fifo_pop_c = 1'b1;
                    state_d    = ST_READ_DATA;
                end
            end
            ST_READ_DATA: begin
                if (avl_rdata_valid && rd_last_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Inbound frame tracking: latched frame ID and saturating beat count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fid_bin_q  <= '0;
            fid_dest_q <= '0;
            wr_len_q   <= '0;
        end else if (accept_c) begin
            if (in_sop_c) begin
                fid_bin_q  <= in_bin_c;
                fid_dest_q <= in_dest_c;
            end
            wr_len_q <= len_next_c;
        end
    end

    // Readback tracking: captured queue entry and returned-beat counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cmd_q <= '0;
            rd_cnt_q <= '0;
        end else if (state_q == ST_READ_REQ && avl_ready) begin
            rd_cmd_q <= head_c;
            rd_cnt_q <= '0;
        end else if (state_q == ST_READ_DATA && avl_rdata_valid) begin
            rd_cnt_q <= rd_cnt_q + LEN_WIDTH'(1);
        end
    end

    // Registered NoC output beat, one cycle after each returned DDR word;
    // the frame ID is rebuilt from dest and bin
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            noc_data_out  <= '0;
            noc_dest_out  <= '0;
            noc_valid_out <= '0;
            noc_sop_out   <= '0;
            noc_eop_out   <= '0;
        end else begin
            noc_valid_out <= '0;
            noc_sop_out   <= '0;
            noc_eop_out   <= '0;
            if (state_q == ST_READ_DATA && avl_rdata_valid) begin
                noc_valid_out <= '1;
                noc_sop_out   <= (rd_cnt_q == '0) ? '1 : '0;
                noc_eop_out   <= rd_last_c ? '1 : '0;
                noc_dest_out  <= rd_cmd_q.dest;
                noc_data_out  <= {rd_cmd_q.dest, FID_MID_WIDTH'(0), rd_cmd_q.bin,
                                  rd_last_c, (rd_cnt_q == '0), avl_rdata};
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_buffer.sv
// Directed bench for eth_frame_buffer: write-path vector table plus readback sequences.
module tb_eth_frame_buffer;
    import eth_fb_pkg::*;

    localparam int unsigned CW = WIDTH_PKT;

    logic                         clk = 1'b0;
    logic                         rst = 1'b0;
    logic [WIDTH_PKT-1:0]         noc_data_in = '0;
    logic [FLIT_WIDTH-1:0]        noc_valid_in = '0;
    logic [FLIT_WIDTH-1:0]        noc_sop_in = '0;
    logic [FLIT_WIDTH-1:0]        noc_eop_in = '0;
    logic                         noc_ready_out;
    logic [WIDTH_PKT-1:0]         noc_data_out;
    logic [NOC_ADDR_WIDTH-1:0]    noc_dest_out;
    logic [FLIT_WIDTH-1:0]        noc_valid_out;
    logic [FLIT_WIDTH-1:0]        noc_sop_out;
    logic [FLIT_WIDTH-1:0]        noc_eop_out;
    logic                         noc_ready_in = 1'b0;
    logic                         avl_ready = 1'b1;
    logic [AVL_ADDR_WIDTH-1:0]    avl_addr;
    logic [AVL_DATA_WIDTH-1:0]    avl_wdata;
    logic [AVL_BYTE_EN_WIDTH-1:0] avl_be;
    logic                         avl_write_req;
    logic                         avl_read_req;
    logic [LEN_WIDTH-1:0]         avl_size;
    logic                         avl_burstbegin;
    logic [AVL_DATA_WIDTH-1:0]    avl_rdata = '0;
    logic                         avl_rdata_valid = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    eth_frame_buffer dut (
        .clk             (clk),
        .rst             (rst),
        .noc_data_in     (noc_data_in),
        .noc_valid_in    (noc_valid_in),
        .noc_sop_in      (noc_sop_in),
        .noc_eop_in      (noc_eop_in),
        .noc_ready_out   (noc_ready_out),
        .noc_data_out    (noc_data_out),
        .noc_dest_out    (noc_dest_out),
        .noc_valid_out   (noc_valid_out),
        .noc_sop_out     (noc_sop_out),
        .noc_eop_out     (noc_eop_out),
        .noc_ready_in    (noc_ready_in),
        .avl_ready       (avl_ready),
        .avl_addr        (avl_addr),
        .avl_wdata       (avl_wdata),
        .avl_be          (avl_be),
        .avl_write_req   (avl_write_req),
        .avl_read_req    (avl_read_req),
        .avl_size        (avl_size),
        .avl_burstbegin  (avl_burstbegin),
        .avl_rdata       (avl_rdata),
        .avl_rdata_valid (avl_rdata_valid)
    );

    typedef struct {
        logic        vld;
        logic        sop;
        logic        eop;
        logic [31:0] fid;
        logic [7:0]  dbin;
        logic [7:0]  beat;
        logic        arq;
        logic        exp_rdy;
        logic        exp_wr;
        logic [28:0] exp_addr;
    } vec_t;

    vec_t vt [11];

    // Recognisable payload per (bin, beat)
    function automatic logic [AVL_DATA_WIDTH-1:0] mkdata(input logic [7:0] bin, input logic [7:0] beat);
        logic [AVL_DATA_WIDTH-1:0] d;
        d = '0;
        d[15:0] = {bin, beat};
        d[AVL_DATA_WIDTH-1 -: 8] = ~beat;
        return d;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic sop, input logic eop,
                         input logic [31:0] fid, input logic [7:0] dbin, input logic [7:0] beat);
        noc_valid_in = vld ? (4'b0001 << beat[1:0]) : 4'b0000;
        noc_data_in  = {fid, eop, sop, mkdata(dbin, beat)};
    endtask

    // Act as DDR for one read burst and check the re-injected NoC beats
    task automatic do_read(input string tag, input logic [28:0] exp_addr, input int len,
                           input logic [3:0] dest, input logic [7:0] bin);
        int t;
        logic [31:0] fid;
        t = 0;
        fid = {dest, 20'h0, bin};
        while (avl_read_req !== 1'b1 && t < 50) begin
            @(negedge clk); #1; t++;
        end
        chk({tag, "_rd_req"}, CW'(avl_read_req), CW'(1'b1));
        if (avl_read_req === 1'b1) begin
            chk({tag, "_rd_addr"}, CW'(avl_addr), CW'(exp_addr));
            chk({tag, "_rd_size"}, CW'(avl_size), CW'(len));
            chk({tag, "_rd_bb"}, CW'(avl_burstbegin), CW'(1'b1));
            @(negedge clk);
            for (int i = 0; i < len; i++) begin
                avl_rdata_valid = 1'b1;
                avl_rdata = mkdata(bin, 8'(i));
                if (i == 0) begin
                    #1 chk({tag, "_pre_valid"}, CW'(noc_valid_out), CW'(4'h0));
                end
                @(negedge clk);
                avl_rdata_valid = 1'b0;
                #1;
                chk({tag, "_out_valid"}, CW'(noc_valid_out), CW'(4'hF));
                chk({tag, "_out_sop"}, CW'(noc_sop_out), CW'((i == 0) ? 4'hF : 4'h0));
                chk({tag, "_out_eop"}, CW'(noc_eop_out), CW'((i == len - 1) ? 4'hF : 4'h0));
                chk({tag, "_out_dest"}, CW'(noc_dest_out), CW'(dest));
                chk({tag, "_out_data"}, noc_data_out,
                    {fid, (i == len - 1), (i == 0), mkdata(bin, 8'(i))});
            end
        end
    endtask

    initial begin
        // Write path vectors: 4-beat frame with a 3-cycle avl_ready stall, then a 1-beat frame
        vt[0]  = '{1, 1, 0, 32'h3000_0005, 8'h05, 8'd0, 1, 1, 1, 29'h0A0};
        vt[1]  = '{1, 0, 0, 32'hFFFF_FFFF, 8'h05, 8'd1, 1, 1, 1, 29'h0A1};
        vt[2]  = '{1, 0, 0, 32'hFFFF_FFFF, 8'h05, 8'd2, 0, 0, 0, 29'h000};
        vt[3]  = '{1, 0, 0, 32'hFFFF_FFFF, 8'h05, 8'd2, 0, 0, 0, 29'h000};
        vt[4]  = '{1, 0, 0, 32'hFFFF_FFFF, 8'h05, 8'd2, 0, 0, 0, 29'h000};
        vt[5]  = '{1, 0, 0, 32'hFFFF_FFFF, 8'h05, 8'd2, 1, 1, 1, 29'h0A2};
        vt[6]  = '{0, 0, 0, 32'h0000_0000, 8'h00, 8'd0, 1, 1, 0, 29'h000};
        vt[7]  = '{1, 0, 1, 32'hFFFF_FFFF, 8'h05, 8'd3, 1, 1, 1, 29'h0A3};
        vt[8]  = '{0, 0, 0, 32'h0000_0000, 8'h00, 8'd0, 1, 1, 0, 29'h000};
        vt[9]  = '{1, 1, 1, 32'h2000_0007, 8'h07, 8'd0, 1, 1, 1, 29'h0E0};
        vt[10] = '{0, 0, 0, 32'h0000_0000, 8'h00, 8'd0, 1, 1, 0, 29'h000};

        // Reset state
        #2;
        chk("rst_ready", CW'(noc_ready_out), CW'(1'b0));
        chk("rst_wr", CW'(avl_write_req), CW'(1'b0));
        chk("rst_rd", CW'(avl_read_req), CW'(1'b0));
        chk("rst_valid_out", CW'(noc_valid_out), CW'(4'h0));
        chk("rst_data_out", noc_data_out, CW'(0));
        chk("rst_be", CW'(avl_be), CW'({AVL_BYTE_EN_WIDTH{1'b1}}));
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk); @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            avl_ready = vt[i].arq;
            drive(vt[i].vld, vt[i].sop, vt[i].eop, vt[i].fid, vt[i].dbin, vt[i].beat);
            #1;
            chk($sformatf("v%0d_ready", i), CW'(noc_ready_out), CW'(vt[i].exp_rdy));
            chk($sformatf("v%0d_wr", i), CW'(avl_write_req), CW'(vt[i].exp_wr));
            chk($sformatf("v%0d_addr", i), CW'(avl_addr), CW'(vt[i].exp_addr));
            chk($sformatf("v%0d_size", i), CW'(avl_size), CW'(vt[i].exp_wr ? 6'd1 : 6'd0));
            chk($sformatf("v%0d_rd", i), CW'(avl_read_req), CW'(1'b0));
            if (vt[i].exp_wr)
                chk($sformatf("v%0d_wdata", i), CW'(avl_wdata), CW'(mkdata(vt[i].dbin, vt[i].beat)));
            @(negedge clk);
        end

        // Readback of both queued frames in order
        avl_ready = 1'b1;
        noc_ready_in = 1'b1;
        do_read("f4", 29'h0A0, 4, 4'h3, 8'h05);
        do_read("f1", 29'h0E0, 1, 4'h2, 8'h07);
        @(negedge clk);
        noc_ready_in = 1'b0;

        // 40-beat frame into bin 1: only the first 32 beats reach DDR
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, (i == 0), (i == 39), (i == 0) ? 32'h1000_0001 : 32'hFFFF_FFFF, 8'h01, 8'(i));
            #1;
            chk($sformatf("f40_b%0d_wr", i), CW'(avl_write_req), CW'(i < 32));
            if (i < 32)
                chk($sformatf("f40_b%0d_addr", i), CW'(avl_addr), CW'(29'h20 + 29'(i)));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        noc_ready_in = 1'b1;
        do_read("f40", 29'h020, 32, 4'h1, 8'h01);
        @(negedge clk);
        noc_ready_in = 1'b0;

        // Five back-to-back 2-beat frames with downstream not ready: queue fills at four
        for (int k = 0; k < 4; k++) begin
            for (int b = 0; b < 2; b++) begin
                drive(1'b1, (b == 0), (b == 1), {4'(k + 4), 20'h0, 8'(10 + k)}, 8'(10 + k), 8'(b));
                #1;
                chk($sformatf("q%0d_b%0d_ready", k, b), CW'(noc_ready_out), CW'(1'b1));
                chk($sformatf("q%0d_b%0d_addr", k, b), CW'(avl_addr),
                    CW'({21'h0, 8'(10 + k), 5'(b)}));
                @(negedge clk);
            end
        end
        drive(1'b1, 1'b1, 1'b0, {4'h8, 20'h0, 8'd14}, 8'd14, 8'd0);
        #1;
        chk("q_full_ready", CW'(noc_ready_out), CW'(1'b0));
        chk("q_full_wr", CW'(avl_write_req), CW'(1'b0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        noc_ready_in = 1'b1;
        for (int k = 0; k < 4; k++)
            do_read($sformatf("q%0d", k), {21'h0, 8'(10 + k), 5'h0}, 2, 4'(k + 4), 8'(10 + k));
        @(negedge clk);
        for (int b = 0; b < 2; b++) begin
            drive(1'b1, (b == 0), (b == 1), {4'h8, 20'h0, 8'd14}, 8'd14, 8'(b));
            #1;
            chk($sformatf("q4_b%0d_wr", b), CW'(avl_write_req), CW'(1'b1));
            chk($sformatf("q4_b%0d_addr", b), CW'(avl_addr), CW'({21'h0, 8'd14, 5'(b)}));
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        do_read("q4", {21'h0, 8'd14, 5'h0}, 2, 4'h8, 8'd14);
        @(negedge clk);
        noc_ready_in = 1'b0;

        // Reset in beat 2 of a frame, with another complete frame already queued
        drive(1'b1, 1'b1, 1'b1, 32'h6000_0020, 8'h20, 8'd0);
        @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            drive(1'b1, (b == 0), 1'b0, 32'h5000_0009, 8'h09, 8'(b));
            if (b < 2) @(negedge clk);
        end
        #2 rst = 1'b0;
        #1;
        chk("mr_ready", CW'(noc_ready_out), CW'(1'b0));
        chk("mr_wr", CW'(avl_write_req), CW'(1'b0));
        chk("mr_addr", CW'(avl_addr), CW'(0));
        chk("mr_wdata", CW'(avl_wdata), CW'(0));
        chk("mr_be", CW'(avl_be), CW'({AVL_BYTE_EN_WIDTH{1'b1}}));
        chk("mr_valid_out", CW'(noc_valid_out), CW'(4'h0));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        rst = 1'b1;
        noc_ready_in = 1'b1;
        begin
            int reads;
            reads = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk); #1;
                if (avl_read_req === 1'b1) reads++;
            end
            chk("mr_no_read", CW'(reads), CW'(0));
        end

        // Recovery: a fresh one-beat frame goes through normally
        drive(1'b1, 1'b1, 1'b1, 32'h7000_0003, 8'h03, 8'd0);
        #1;
        chk("post_wr", CW'(avl_write_req), CW'(1'b1));
        chk("post_addr", CW'(avl_addr), CW'(29'h060));
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 8'h0, 8'h0);
        do_read("post", 29'h060, 1, 4'h7, 8'h03);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
